// File: rtl/demux_rr_if.sv
// Receive-path demux bus: unstripped word input on one side, flattened per-lane outputs on the other.
// master drives the input word; slave is the demux itself.
interface demux_rr_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 2
);
  localparam int PTR_W = $clog2(LANES);

  logic [DATA_W-1:0]       data_unstripped;
  logic                    valid_unstripped;
  logic                    align;
  logic [LANES*DATA_W-1:0] data_demux;
  logic [LANES-1:0]        valid_demux;
  logic [PTR_W-1:0]        lane_sel;
  logic                    wrap;

  modport master (
    output data_unstripped, valid_unstripped, align,
    input  data_demux, valid_demux, lane_sel, wrap
  );

  modport slave (
    input  data_unstripped, valid_unstripped, align,
    output data_demux, valid_demux, lane_sel, wrap
  );
endinterface

// File: rtl/demux_rr.sv
// Round-robin 1:LANES demux with registered outputs, align resync and wrap pulse.
// Define DEMUX_IDLE_ADVANCE_EN to let idle cycles advance the lane pointer (legacy behaviour).
module demux_rr_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              vld
);
  // Data is only ever overwritten by a new word; consumers qualify with vld.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      dout <= '0;
      vld  <= 1'b0;
    end else begin
      vld <= load;
      if (load) dout <= din;
    end
  end
endmodule

module demux_rr #(
  parameter int DATA_W = 8,
  parameter int LANES  = 2
) (
  input  logic      clk_2f,
  input  logic      reset_L,
  demux_rr_if.slave bus
);
  localparam int              PTR_W = $clog2(LANES);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(LANES - 1);

  logic [PTR_W-1:0]             ptr, ptr_nxt, tgt;
  logic                         last, wrap_q;
  logic [LANES-1:0]             load, vld;
  logic [LANES-1:0][DATA_W-1:0] lane_data;

  // Explicit compare keeps non-power-of-two LANES from ever reaching an unused code.
  assign last = (ptr == LAST);
  assign tgt  = bus.align ? '0 : ptr;

  always_comb begin
    ptr_nxt = ptr;
    if (bus.align)                 ptr_nxt = bus.valid_unstripped ? PTR_W'(1) : '0;
    else if (bus.valid_unstripped) ptr_nxt = last ? '0 : ptr + PTR_W'(1);
`ifdef DEMUX_IDLE_ADVANCE_EN
    else                           ptr_nxt = last ? '0 : ptr + PTR_W'(1);
`else
    else                           ptr_nxt = ptr;
`endif
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      ptr    <= '0;
      wrap_q <= 1'b0;
    end else begin
      ptr    <= ptr_nxt;
      wrap_q <= bus.valid_unstripped && !bus.align && last;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign load[i] = bus.valid_unstripped && (tgt == PTR_W'(i));
    demux_rr_lane #(.DATA_W(DATA_W)) u_lane (
      .clk_2f  (clk_2f),
      .reset_L (reset_L),
      .load    (load[i]),
      .din     (bus.data_unstripped),
      .dout    (lane_data[i]),
      .vld     (vld[i])
    );
  end

  assign bus.data_demux  = lane_data;
  assign bus.valid_demux = vld;
  assign bus.lane_sel    = ptr;
  assign bus.wrap        = wrap_q;
endmodule

// File: tb/tb_demux_rr.sv
// Scoreboard bench for demux_rr at LANES=3 (non-power-of-two), DATA_W=8.
// Expected idle behaviour follows DEMUX_IDLE_ADVANCE_EN when the bench is built with it.
module tb_demux_rr;
  localparam int DATA_W = 8;
  localparam int LANES  = 3;

  typedef struct {
    int         lane;
    logic [7:0] data;
    bit         wrap;
    int         sel;
  } exp_t;

  logic clk_2f;
  logic reset_L;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  demux_rr_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

  demux_rr #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial begin
    clk_2f = 1'b0;
    forever #5 clk_2f = ~clk_2f;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every delivered word is matched against the oldest expectation.
  always @(negedge clk_2f) begin
    if (reset_L) begin
      chk("onehot_or_zero", 32'($countones(bus.valid_demux) <= 1), 32'd1);
      chk("lane_sel_range", 32'(bus.lane_sel < LANES), 32'd1);
      if (bus.valid_demux != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {29'd0, bus.valid_demux}, 32'd0);
        end else begin
          exp_t e;
          logic [31:0] one;
          e   = sb.pop_front();
          one = 32'd1 << e.lane;
          chk("valid_demux", {29'd0, bus.valid_demux}, one);
          chk("lane_data", {24'd0, bus.data_demux[e.lane*DATA_W +: DATA_W]}, {24'd0, e.data});
          chk("wrap", {31'd0, bus.wrap}, {31'd0, e.wrap});
          chk("lane_sel", {30'd0, bus.lane_sel}, 32'(e.sel));
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit al, input int lane, input bit w, input int sel);
    exp_t e;
    bus.data_unstripped  = d;
    bus.valid_unstripped = 1'b1;
    bus.align            = al;
    e.lane = lane; e.data = d; e.wrap = w; e.sel = sel;
    sb.push_back(e);
    @(posedge clk_2f); #1;
  endtask

  // Non-delivery cycle; optionally confirm a lane still holds its last word.
  task automatic idle(input bit al, input int sel, input int lane, input logic [7:0] d);
    bus.valid_unstripped = 1'b0;
    bus.align            = al;
    @(posedge clk_2f); #1;
    chk("idle_valid", {29'd0, bus.valid_demux}, 32'd0);
    chk("idle_wrap", {31'd0, bus.wrap}, 32'd0);
    chk("idle_lane_sel", {30'd0, bus.lane_sel}, 32'(sel));
    if (lane >= 0)
      chk("idle_hold", {24'd0, bus.data_demux[lane*DATA_W +: DATA_W]}, {24'd0, d});
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_data"}, {8'd0, bus.data_demux}, 32'd0);
    chk({nm, "_valid"}, {29'd0, bus.valid_demux}, 32'd0);
    chk({nm, "_sel"}, {30'd0, bus.lane_sel}, 32'd0);
    chk({nm, "_wrap"}, {31'd0, bus.wrap}, 32'd0);
  endtask

  initial begin
    bus.data_unstripped  = '0;
    bus.valid_unstripped = 1'b0;
    bus.align            = 1'b0;
    reset_L = 1'b1;
    #1 reset_L = 1'b0;
    #1 chk_reset_outs("por");
    repeat (2) @(posedge clk_2f);
    #1 reset_L = 1'b1;

    // Back-to-back rotation with wrap on the last lane
    send(8'h10, 0, 0, 0, 1);
    send(8'h11, 0, 1, 0, 2);
    send(8'h12, 0, 2, 1, 0);
    send(8'h13, 0, 0, 0, 1);
    send(8'h14, 0, 1, 0, 2);
    send(8'h15, 0, 2, 1, 0);

    // Idle gap between two words
    send(8'h01, 0, 0, 0, 1);
`ifdef DEMUX_IDLE_ADVANCE_EN
    idle(0, 2, 0, 8'h01);
    send(8'h02, 0, 2, 1, 0);
`else
    idle(0, 1, 0, 8'h01);
    send(8'h02, 0, 1, 0, 2);
`endif
    idle(1, 0, 0, 8'h01);

    // Align with a word while ptr sits on the last lane: no wrap, lane 0
    send(8'h20, 0, 0, 0, 1);
    send(8'h21, 0, 1, 0, 2);
    send(8'h77, 1, 0, 0, 1);
    idle(1, 0, 0, 8'h77);
    send(8'h30, 0, 0, 0, 1);
    send(8'h31, 0, 1, 0, 2);

    // Idle at the last lane
`ifdef DEMUX_IDLE_ADVANCE_EN
    idle(0, 0, 1, 8'h31);
    idle(0, 1, 1, 8'h31);
`else
    idle(0, 2, 1, 8'h31);
    idle(0, 2, 1, 8'h31);
`endif
    idle(1, 0, -1, 8'h00);

    // Mid-stream reset discards the partial group
    send(8'h40, 0, 0, 0, 1);
    send(8'h41, 0, 1, 0, 2);
    @(negedge clk_2f); #1;
    bus.data_unstripped  = 8'h99;
    bus.valid_unstripped = 1'b1;
    reset_L = 1'b0;
    #1 chk_reset_outs("rst_now");
    repeat (2) @(posedge clk_2f);
    #1 chk_reset_outs("rst_held");
    bus.valid_unstripped = 1'b0;
    reset_L = 1'b1;
    send(8'hA5, 0, 0, 0, 1);
    idle(0, 1, 1, 8'h00);

    // Pseudo-random payloads over three full groups
    idle(1, 0, -1, 8'h00);
    for (int i = 0; i < 9; i++)
      send(8'($urandom_range(0, 255)), 0, i % 3, (i % 3) == 2, (i + 1) % 3);
    idle(0, 0, -1, 8'h00);

    repeat (2) @(posedge clk_2f);
    #1 chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
